// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the 8-source round-robin bus arbiter.
package bus_arbiter_pkg;

   localparam int BUS_W   = 8;
   localparam int NUM_SRC = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set, non-excluded request bit
// scanning upward from pointer+1 with wrap, so the pointer position comes last.
module rr_pick
   import bus_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   pointer,
   input  logic [NUM_SRC-1:0] exclude,
   output logic               valid,
   output logic [SEL_W-1:0]   index
);

   logic [NUM_SRC-1:0] masked;
   logic [NUM_SRC-1:0] rot;
   logic [SEL_W-1:0]   offset;

   assign masked = req & ~exclude;

   // rot[k] is the candidate k+1 places after the pointer (mod 8).
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_rot
         logic [SEL_W-1:0] src;
         assign src     = pointer + SEL_W'(gi + 1);
         assign rot[gi] = masked[src];
      end
   endgenerate

   always_comb begin
      valid  = 1'b0;
      offset = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid  = 1'b1;
            offset = SEL_W'(i);
         end
      end
   end

   assign index = pointer + offset + SEL_W'(1);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter driving an 8:1 bus mux (one-hot gnt, binary sel, bus_en).
// Optional hold-limit revocation is built when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   output logic [NUM_SRC-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               bus_en,
   output logic               timeout
);

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
         $error("bus_arbiter: MAX_HOLD must be within 2..255");
      end
   endgenerate

   arb_state_t         state_reg, state_next;
   logic [NUM_SRC-1:0] gnt_reg, gnt_next;
   logic [SEL_W-1:0]   sel_reg, sel_next;
   logic [SEL_W-1:0]   ptr_reg, ptr_next;
   logic               pick_valid;
   logic [SEL_W-1:0]   pick_index;
   logic               owner_req;
   logic               hold_expired;
   logic               take_grant;

   // Excluding the current owner is harmless on release (its bit is already 0)
   // and is exactly what hold-limit revocation needs.
   rr_pick u_pick (
      .req     (req),
      .pointer (ptr_reg),
      .exclude (gnt_reg),
      .valid   (pick_valid),
      .index   (pick_index)
   );

   assign owner_req = req[sel_reg];

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt_reg, hold_cnt_next;
   logic       timeout_reg, timeout_next;

   assign hold_expired = (hold_cnt_reg == HOLD_LIMIT);

   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      if (take_grant)
         hold_cnt_next = '0;
      else if (state_reg == OWNED && !hold_expired)
         hold_cnt_next = hold_cnt_reg + 8'd1;
      timeout_next = (state_reg == OWNED) && owner_req && hold_expired && pick_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         hold_cnt_reg <= hold_cnt_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign timeout = timeout_reg;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      sel_next   = sel_reg;
      ptr_next   = ptr_reg;
      take_grant = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid)
               take_grant = 1'b1;
         end
         OWNED: begin
            if (!owner_req) begin
               if (pick_valid) begin
                  take_grant = 1'b1;
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
               end
            end else if (hold_expired && pick_valid) begin
               take_grant = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
      if (take_grant) begin
         state_next = OWNED;
         gnt_next   = onehot(pick_index);
         sel_next   = pick_index;
         ptr_next   = pick_index;
      end
   end

   // Pointer resets to 7 so requester 0 is first in search order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         sel_reg   <= '0;
         ptr_reg   <= '1;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         sel_reg   <= sel_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign gnt    = gnt_reg;
   assign sel    = sel_reg;
   assign bus_en = |gnt_reg;

endmodule
